// File: rtl/eco32f_regfile_fwd_if.sv
// Bus between the eco32f pipeline controller and the register file with forwarding.
// The master drives the stage controls; the slave (register file) returns MEM destination and operands.
interface eco32f_regfile_fwd_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
);
    logic                           id_stall;
    logic                           ex_stall;
    logic                           ex_flush;
    logic [NUM_READ*ADDR_WIDTH-1:0] id_rf_rd_addr;
    logic [NUM_READ-1:0]            id_rf_rd_valid;
    logic [ADDR_WIDTH-1:0]          ex_rf_r_addr;
    logic                           ex_rf_r_we;
    logic                           ex_is_load;
    logic [DATA_WIDTH-1:0]          mem_alu_result;
    logic [ADDR_WIDTH-1:0]          wb_rf_r_addr;
    logic                           wb_rf_r_we;
    logic [DATA_WIDTH-1:0]          wb_rf_r;
    logic [ADDR_WIDTH-1:0]          mem_rf_r_addr;
    logic                           mem_rf_r_we;
    logic [NUM_READ*DATA_WIDTH-1:0] ex_rf_rd;
    logic                           ex_load_use_stall;

    modport master (
        output id_stall, ex_stall, ex_flush, id_rf_rd_addr, id_rf_rd_valid,
               ex_rf_r_addr, ex_rf_r_we, ex_is_load, mem_alu_result,
               wb_rf_r_addr, wb_rf_r_we, wb_rf_r,
        input  mem_rf_r_addr, mem_rf_r_we, ex_rf_rd, ex_load_use_stall
    );

    modport slave (
        input  id_stall, ex_stall, ex_flush, id_rf_rd_addr, id_rf_rd_valid,
               ex_rf_r_addr, ex_rf_r_we, ex_is_load, mem_alu_result,
               wb_rf_r_addr, wb_rf_r_we, wb_rf_r,
        output mem_rf_r_addr, mem_rf_r_we, ex_rf_rd, ex_load_use_stall
    );
endinterface

// File: rtl/eco32f_regfile_fwd.sv
// eco32f register file: N read ports captured at ID, resolved in EX against MEM/WB
// destinations every cycle, with load-use stall detection for a load sitting in MEM.
module eco32f_regfile_fwd #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic                clk,
    input  logic                rst,
    eco32f_regfile_fwd_if.slave bus
);
    localparam int   DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic ZERO_EN = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] reg_array_r [DEPTH];
    logic [ADDR_WIDTH-1:0] ex_src_addr_r [NUM_READ];
    logic [NUM_READ-1:0]   ex_src_valid_r;
    logic [DATA_WIDTH-1:0] op_r [NUM_READ];
    logic [ADDR_WIDTH-1:0] mem_rf_r_addr_r;
    logic                  mem_rf_r_we_r;
    logic                  mem_is_load_r;

    logic [NUM_READ*DATA_WIDTH-1:0] ex_rf_rd_s;
    logic                           load_use_s;

    // Architectural array write port (WB); contents intentionally not reset
    always_ff @(posedge clk) begin
        if (bus.wb_rf_r_we) begin
            reg_array_r[bus.wb_rf_r_addr] <= bus.wb_rf_r;
        end
    end

    // EX->MEM destination pipeline registers; flush beats stall
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rf_r_addr_r <= {ADDR_WIDTH{1'b0}};
            mem_rf_r_we_r   <= 1'b0;
            mem_is_load_r   <= 1'b0;
        end else begin
            if (!bus.ex_stall) begin
                mem_rf_r_addr_r <= bus.ex_rf_r_addr;
                mem_rf_r_we_r   <= bus.ex_rf_r_we;
                mem_is_load_r   <= bus.ex_is_load;
            end
            if (bus.ex_flush) begin
                mem_rf_r_we_r <= 1'b0;
                mem_is_load_r <= 1'b0;
            end
        end
    end

    // ID->EX operand capture (write-first) and WB refresh of held operands
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_src_valid_r <= {NUM_READ{1'b0}};
            for (int i = 0; i < NUM_READ; i++) begin
                ex_src_addr_r[i] <= {ADDR_WIDTH{1'b0}};
                op_r[i]          <= {DATA_WIDTH{1'b0}};
            end
        end else if (!bus.id_stall) begin
            ex_src_valid_r <= bus.id_rf_rd_valid;
            for (int i = 0; i < NUM_READ; i++) begin
                ex_src_addr_r[i] <= bus.id_rf_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                if (bus.wb_rf_r_we &&
                    bus.wb_rf_r_addr == bus.id_rf_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    op_r[i] <= bus.wb_rf_r;
                end else begin
                    op_r[i] <= reg_array_r[bus.id_rf_rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
                end
            end
        end else begin
            // A long stall must not lose a write that lands while the operand waits
            for (int i = 0; i < NUM_READ; i++) begin
                if (bus.wb_rf_r_we && bus.wb_rf_r_addr == ex_src_addr_r[i]) begin
                    op_r[i] <= bus.wb_rf_r;
                end else begin
                    op_r[i] <= op_r[i];
                end
            end
        end
    end

    // Per-port EX operand resolution (MEM newer than WB) and load-use detection
    always_comb begin
        ex_rf_rd_s = {NUM_READ*DATA_WIDTH{1'b0}};
        load_use_s = 1'b0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (ZERO_EN && ex_src_addr_r[i] == {ADDR_WIDTH{1'b0}}) begin
                ex_rf_rd_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
            end else if (mem_rf_r_we_r && mem_rf_r_addr_r == ex_src_addr_r[i]) begin
                ex_rf_rd_s[i*DATA_WIDTH +: DATA_WIDTH] = bus.mem_alu_result;
                if (ex_src_valid_r[i] && mem_is_load_r) begin
                    load_use_s = 1'b1;
                end else begin
                    load_use_s = load_use_s;
                end
            end else if (bus.wb_rf_r_we && bus.wb_rf_r_addr == ex_src_addr_r[i]) begin
                ex_rf_rd_s[i*DATA_WIDTH +: DATA_WIDTH] = bus.wb_rf_r;
            end else begin
                ex_rf_rd_s[i*DATA_WIDTH +: DATA_WIDTH] = op_r[i];
            end
        end
    end

    assign bus.mem_rf_r_addr     = mem_rf_r_addr_r;
    assign bus.mem_rf_r_we       = mem_rf_r_we_r;
    assign bus.ex_rf_rd          = ex_rf_rd_s;
    assign bus.ex_load_use_stall = load_use_s;
endmodule

// File: tb/tb_eco32f_regfile_fwd.sv
// Directed bench for eco32f_regfile_fwd (4 read ports): stimulus queues expectations
// tagged with a cycle number; a monitor compares them mid-cycle on the falling edge.
module tb_eco32f_regfile_fwd;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;

    localparam int K_OP    = 0;
    localparam int K_STALL = 1;
    localparam int K_MWE   = 2;
    localparam int K_MADDR = 3;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;
    bit   summarised = 1'b0;
    exp_t sb[$];

    eco32f_regfile_fwd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus ();

    eco32f_regfile_fwd #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_stall       = 1'b0;
        bus.ex_stall       = 1'b0;
        bus.ex_flush       = 1'b0;
        bus.id_rf_rd_addr  = '0;
        bus.id_rf_rd_valid = '0;
        bus.ex_rf_r_addr   = '0;
        bus.ex_rf_r_we     = 1'b0;
        bus.ex_is_load     = 1'b0;
        bus.mem_alu_result = '0;
        bus.wb_rf_r_addr   = '0;
        bus.wb_rf_r_we     = 1'b0;
        bus.wb_rf_r        = '0;
    endtask

    task automatic id_read(input int p, input logic [AW-1:0] a);
        bus.id_rf_rd_addr[p*AW +: AW] = a;
        bus.id_rf_rd_valid[p]         = 1'b1;
    endtask

    task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_rf_r_we   = 1'b1;
        bus.wb_rf_r_addr = a;
        bus.wb_rf_r      = d;
    endtask

    task automatic ex_dest(input logic [AW-1:0] a, input logic ld);
        bus.ex_rf_r_we   = 1'b1;
        bus.ex_rf_r_addr = a;
        bus.ex_is_load   = ld;
    endtask

    task automatic push(input string n, input int k, input int p, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc;
        e.name = n;
        e.kind = k;
        e.port = p;
        e.val  = v;
        sb.push_back(e);
    endtask

    // Monitor: compares every expectation due this cycle, then the final summary
    always @(negedge clk) begin
        logic [31:0] act;
        exp_t        e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            case (e.kind)
                K_OP:    act = bus.ex_rf_rd[e.port*DW +: DW];
                K_STALL: act = {31'd0, bus.ex_load_use_stall};
                K_MWE:   act = {31'd0, bus.mem_rf_r_we};
                K_MADDR: act = {27'd0, bus.mem_rf_r_addr};
                default: act = 32'hxxxx_xxxx;
            endcase
            total++;
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: expectation for cycle %0d checked late at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.val) begin
                bad++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", e.name, act, e.val, cyc);
            end
        end
        if (done && !summarised) begin
            summarised = 1'b1;
            total++;
            if (sb.size() != 0) begin
                bad++;
                $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int p = 0; p < NR; p++) push("reset_op", K_OP, p, 32'h0);
        push("reset_stall", K_STALL, 0, 32'h0);
        push("reset_mem_we", K_MWE, 0, 32'h0);
        push("reset_mem_addr", K_MADDR, 0, 32'h0);
        tick();

        // Plain read of r5 through the array
        wb_write(5'd5, 32'h1234_5678);
        tick();
        idle();
        tick();
        tick();
        id_read(0, 5'd5);
        tick();
        idle();
        push("plain_read_r5", K_OP, 0, 32'h1234_5678);
        tick();

        // EX->MEM forward, MEM beats WB, flush under stall, hold refresh
        ex_dest(5'd3, 1'b0);
        id_read(1, 5'd3);
        tick();
        idle();
        bus.id_stall = 1'b1;
        bus.ex_stall = 1'b1;
        bus.mem_alu_result = 32'hDEAD_BEEF;
        push("mem_fwd_r3", K_OP, 1, 32'hDEAD_BEEF);
        push("mem_we_alu", K_MWE, 0, 32'h1);
        push("mem_addr_alu", K_MADDR, 0, 32'h3);
        push("alu_no_stall", K_STALL, 0, 32'h0);
        tick();
        wb_write(5'd3, 32'h0000_1111);
        bus.ex_flush = 1'b1;
        push("mem_over_wb_r3", K_OP, 1, 32'hDEAD_BEEF);
        tick();
        bus.wb_rf_r_we = 1'b0;
        bus.ex_flush   = 1'b0;
        bus.ex_stall   = 1'b0;
        push("flush_under_stall", K_MWE, 0, 32'h0);
        push("hold_refresh_r3", K_OP, 1, 32'h0000_1111);
        tick();
        idle();
        tick();

        // Load-use on r7, bubble, then WB forward
        ex_dest(5'd7, 1'b1);
        id_read(0, 5'd7);
        tick();
        idle();
        bus.id_stall = 1'b1;
        bus.mem_alu_result = 32'hBAD0_BAD0;
        push("load_use_stall", K_STALL, 0, 32'h1);
        tick();
        bus.id_stall = 1'b0;
        bus.mem_alu_result = 32'h0;
        wb_write(5'd7, 32'h0000_CAFE);
        push("load_use_release", K_STALL, 0, 32'h0);
        push("load_wb_fwd_r7", K_OP, 0, 32'h0000_CAFE);
        tick();
        idle();
        tick();

        // Long hold on r9 with one WB update mid-stall
        wb_write(5'd9, 32'h0000_0001);
        tick();
        idle();
        id_read(2, 5'd9);
        tick();
        idle();
        bus.id_stall = 1'b1;
        push("hold_c1_old", K_OP, 2, 32'h0000_0001);
        tick();
        wb_write(5'd9, 32'h0000_0002);
        push("hold_c2_wb", K_OP, 2, 32'h0000_0002);
        tick();
        bus.wb_rf_r_we = 1'b0;
        push("hold_c3", K_OP, 2, 32'h0000_0002);
        tick();
        push("hold_c4", K_OP, 2, 32'h0000_0002);
        tick();
        bus.id_stall = 1'b0;
        push("hold_release", K_OP, 2, 32'h0000_0002);
        tick();
        idle();
        tick();

        // r0 is never forwarded and never stalls
        wb_write(5'd0, 32'hFFFF_FFFF);
        tick();
        idle();
        ex_dest(5'd0, 1'b1);
        id_read(3, 5'd0);
        tick();
        idle();
        bus.mem_alu_result = 32'hFFFF_FFFF;
        wb_write(5'd0, 32'hFFFF_FFFF);
        push("zero_reg_read", K_OP, 3, 32'h0);
        push("zero_reg_no_stall", K_STALL, 0, 32'h0);
        tick();
        idle();
        tick();

        // Four ports resolving from array, WB, MEM and array independently
        wb_write(5'd10, 32'h0000_000A);
        tick();
        wb_write(5'd13, 32'h0000_000D);
        tick();
        idle();
        id_read(0, 5'd10);
        id_read(1, 5'd11);
        id_read(2, 5'd12);
        id_read(3, 5'd13);
        ex_dest(5'd12, 1'b0);
        tick();
        idle();
        bus.mem_alu_result = 32'h0000_C0C0;
        wb_write(5'd11, 32'h0000_00B1);
        push("quad_p0_array", K_OP, 0, 32'h0000_000A);
        push("quad_p1_wb", K_OP, 1, 32'h0000_00B1);
        push("quad_p2_mem", K_OP, 2, 32'h0000_C0C0);
        push("quad_p3_array", K_OP, 3, 32'h0000_000D);
        tick();
        idle();
        tick();

        // Reset while stalled with pending forwards
        ex_dest(5'd10, 1'b1);
        id_read(0, 5'd10);
        tick();
        idle();
        bus.id_stall = 1'b1;
        bus.ex_stall = 1'b1;
        wb_write(5'd10, 32'h0000_0055);
        rst = 1'b1;
        push("pre_reset_stall", K_STALL, 0, 32'h1);
        tick();
        rst = 1'b0;
        idle();
        for (int p = 0; p < NR; p++) push("post_reset_op", K_OP, p, 32'h0);
        push("post_reset_stall", K_STALL, 0, 32'h0);
        push("post_reset_mem_we", K_MWE, 0, 32'h0);
        push("post_reset_mem_addr", K_MADDR, 0, 32'h0);
        tick();
        tick();
        done = 1'b1;
    end
endmodule

// File: doc/eco32f_regfile_fwd.md
# eco32f_regfile_fwd

Parametrised register file with N read ports, EX-stage operand forwarding and load-use hazard detection for the eco32f pipeline. It sits between decode (ID) and execute (EX). It owns the architectural register array and the EX→MEM destination pipeline registers. Each EX operand is resolved every cycle against the MEM and WB destinations, so forwarding stays correct across arbitrary stalls. It asserts a stall request when an EX operand depends on a load still in MEM.

## Interface
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; array depth = 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 always reads 0 and is never forwarded
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- id_stall  in  1  hold ID→EX operand capture
- ex_stall  in  1  hold EX→MEM destination registers
- ex_flush  in  1  squash the EX instruction entering MEM (forces mem_rf_r_we=0)
- id_rf_rd_addr  in  NUM_READ*ADDR_WIDTH  ID source addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- id_rf_rd_valid  in  NUM_READ  port i is a real source operand
- ex_rf_r_addr  in  ADDR_WIDTH  EX destination address
- ex_rf_r_we  in  1  EX instruction writes a register
- ex_is_load  in  1  EX instruction is a load; its result is not in mem_alu_result
- mem_alu_result  in  DATA_WIDTH  MEM-stage result of the instruction now in MEM
- wb_rf_r_addr  in  ADDR_WIDTH  WB write address
- wb_rf_r_we  in  1  WB write enable
- wb_rf_r  in  DATA_WIDTH  WB write data
- mem_rf_r_addr  out  ADDR_WIDTH  registered MEM destination address
- mem_rf_r_we  out  1  registered MEM write enable
- ex_rf_rd  out  NUM_READ*DATA_WIDTH  resolved EX operands, packed like id_rf_rd_addr
- ex_load_use_stall  out  1  EX operand waits on a load in MEM

## Operation
- Array: 2**ADDR_WIDTH × DATA_WIDTH flops, one write port (WB) and NUM_READ read ports. Contents are not reset.
- ID capture: when !id_stall, each port registers ex_src_addr[i] ← id address, ex_src_valid[i] ← id valid, and op_q[i] ← array[id addr]. The read is write-first: if the WB write hits the same address in that cycle, op_q takes wb_rf_r.
- Hold refresh: when id_stall, op_q[i] ← wb_rf_r if wb_rf_r_we and wb_rf_r_addr == ex_src_addr[i]. Otherwise op_q holds.
- EX resolution, per port, in priority order:
  - 0 if ZERO_REG and ex_src_addr[i]==0
  - mem_alu_result if mem_rf_r_we and mem_rf_r_addr matches
  - wb_rf_r if wb_rf_r_we and wb_rf_r_addr matches
  - op_q[i] otherwise
- Load-use: ex_load_use_stall = OR over ports of (ex_src_valid[i] & mem_rf_r_we & mem_is_load & mem_rf_r_addr == ex_src_addr[i] & !(ZERO_REG & addr==0)). The pipeline controller stalls ID/EX and inserts a MEM bubble. On the next cycle the load is in WB and the WB forward applies.
- MEM registers: when !ex_stall, mem_rf_r_addr ← ex_rf_r_addr, mem_rf_r_we ← ex_rf_r_we, mem_is_load ← ex_is_load. If ex_flush, mem_rf_r_we ← 0 and mem_is_load ← 0, overriding ex_stall.
- WB writes to register 0 update the array when ZERO_REG=0. When ZERO_REG=1 they are harmless because the read is masked.

## Timing
- Reset values:
  - mem_rf_r_addr=0, mem_rf_r_we=0, mem_is_load=0
  - ex_src_addr=0, ex_src_valid=0, op_q=0
  - therefore ex_rf_rd=0 and ex_load_use_stall=0 in the first cycle after reset
- rst overrides id_stall, ex_stall and ex_flush. Reset mid-stall clears all captured state.
- Latency: ID address at edge k gives the operand on ex_rf_rd during cycle k+1.
- ex_rf_rd and ex_load_use_stall are combinational from registered state plus the mem/wb inputs. There is no further latency.
- Load-use stall lasts exactly one cycle per dependent load, provided the controller bubbles MEM.
- Simultaneous MEM and WB match on the same address: MEM wins (newer).

## Test plan
- Plain read: write r5=0x1234_5678 via WB, idle 2 cycles, ID reads r5 on port 0 -> next cycle ex_rf_rd[0]=0x12345678.
- EX forward: EX writes r3 (ALU), ID reads r3 on port 1 the same cycle; next cycle mem_alu_result=0xDEAD_BEEF -> ex_rf_rd[1]=0xDEADBEEF. With r3 also in WB (0x1111) -> still 0xDEADBEEF.
- Load-use: EX load to r7, ID reads r7 -> next cycle ex_load_use_stall=1. Controller bubbles; WB writes r7=0xCAFE -> stall=0 and ex_rf_rd=0xCAFE.
- Long hold: capture r9 (old 0x1), assert id_stall 4 cycles, WB writes r9=0x2 in cycle 2 and nothing after -> ex_rf_rd=0x2 from cycle 2 through release.
- Zero/flush: read r0 while EX/MEM/WB all target r0 with 0xFFFF_FFFF -> 0 and no stall. ex_flush with ex_stall=1 -> mem_rf_r_we=0 next cycle.
- Reset mid-operation: assert rst during id_stall with pending forwards -> next cycle all outputs 0. With NUM_READ=4, all four ports resolve independently.
